// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: accepts packet bytes, shifts them out LSB-first at the bit rate
// into the bit stuffer, then requests EOP. Define USB_TX_SERIALIZER_SYNC_EN to prepend SYNC.
module usb_tx_serializer #(
    parameter int unsigned BIT_PERIOD   = 1,
`ifdef USB_TX_SERIALIZER_SYNC_EN
    parameter logic [7:0]  SYNC_PATTERN = 8'h80,
`endif
    parameter int unsigned EOP_BITS     = 2
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    input  logic       stall,
    output logic       out_bit,
    output logic       out_en,
    output logic       eop,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned TICK_W  = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int unsigned EOP_CYC = EOP_BITS * BIT_PERIOD;
    localparam int unsigned EOP_W   = (EOP_CYC > 1) ? $clog2(EOP_CYC) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(BIT_PERIOD - 1);
    localparam logic [EOP_W-1:0]  EOP_MAX  = EOP_W'(EOP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_DATA = 2'd2,
        S_EOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          sreg_q, sreg_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [EOP_W-1:0]    eop_cnt_q, eop_cnt_d;
    logic [7:0]          hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                hold_last_q, hold_last_d;
    logic                last_seen_q, last_seen_d;
    logic                cur_last_q, cur_last_d;
    logic                underrun_q, underrun_d;

    logic in_tx;
    logic strobe;
    logic consume;
    logic byte_done;
    logic accept;
    logic eop_done;

    assign in_tx     = (state_q == S_SYNC) || (state_q == S_DATA);
    assign strobe    = in_tx && (tick_q == TICK_MAX);
    assign consume   = strobe && !stall;
    assign byte_done = consume && (bit_idx_q == 3'd7);
    assign accept    = data_valid && data_ready;
    assign eop_done  = (state_q == S_EOP) && (eop_cnt_q == EOP_MAX);

    // State register
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef USB_TX_SERIALIZER_SYNC_EN
                    state_d = S_SYNC;
`else
                    state_d = S_DATA;
`endif
                end
            end
            S_SYNC: begin
                if (byte_done) state_d = S_DATA;
            end
            S_DATA: begin
                if (byte_done && (cur_last_q || !hold_valid_q)) state_d = S_EOP;
            end
            S_EOP: begin
                if (eop_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: shifter, holding register, bit/EOP timers
    always_comb begin
        sreg_d       = sreg_q;
        bit_idx_d    = bit_idx_q;
        tick_d       = '0;
        eop_cnt_d    = '0;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        hold_last_d  = hold_last_q;
        last_seen_d  = last_seen_q;
        cur_last_d   = cur_last_q;
        underrun_d   = 1'b0;

        if (in_tx) begin
            tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + TICK_W'(1);
        end
        if ((state_q == S_EOP) && !eop_done) begin
            eop_cnt_d = eop_cnt_q + EOP_W'(1);
        end
        if (consume) begin
            sreg_d    = {1'b0, sreg_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
        end
        if (accept) begin
            hold_d       = data_in;
            hold_valid_d = 1'b1;
            hold_last_d  = data_last;
            if (data_last) last_seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    bit_idx_d = 3'd0;
`ifdef USB_TX_SERIALIZER_SYNC_EN
                    sreg_d = SYNC_PATTERN;
`else
                    sreg_d       = data_in;
                    cur_last_d   = data_last;
                    hold_valid_d = 1'b0;
`endif
                end
            end
            S_SYNC: begin
                // Load reads the old hold contents; a same-cycle accept refills it
                if (byte_done) begin
                    sreg_d       = hold_q;
                    cur_last_d   = hold_last_q;
                    hold_valid_d = accept;
                end
            end
            S_DATA: begin
                if (byte_done && !cur_last_q) begin
                    if (hold_valid_q) begin
                        sreg_d       = hold_q;
                        cur_last_d   = hold_last_q;
                        hold_valid_d = accept;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            S_EOP: begin
                // Anything left over from an aborted packet is dropped
                if (eop_done) begin
                    sreg_d       = '0;
                    hold_valid_d = 1'b0;
                    hold_last_d  = 1'b0;
                    last_seen_d  = 1'b0;
                    cur_last_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (RST) begin
            sreg_q       <= '0;
            bit_idx_q    <= '0;
            tick_q       <= '0;
            eop_cnt_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            last_seen_q  <= 1'b0;
            cur_last_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            sreg_q       <= sreg_d;
            bit_idx_q    <= bit_idx_d;
            tick_q       <= tick_d;
            eop_cnt_q    <= eop_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
            last_seen_q  <= last_seen_d;
            cur_last_q   <= cur_last_d;
            underrun_q   <= underrun_d;
        end
    end

    // Output decode, all from registered state
    always_comb begin
        data_ready = !hold_valid_q && (state_q != S_EOP) && !last_seen_q;
        out_en     = strobe;
        out_bit    = in_tx && sreg_q[0];
        eop        = (state_q == S_EOP);
        busy       = (state_q != S_IDLE);
        underrun   = underrun_q;
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer: table-driven and randomized packets into two serializer instances
// (bit period 1 and 4); consumed bits are compared to SYNC + LSB-first payload.
module tb_usb_tx_serializer;

`ifdef USB_TX_SERIALIZER_SYNC_EN
    localparam int SB = 8;
`else
    localparam int SB = 0;
`endif
    localparam int EOP_BITS = 2;

    logic       clk = 1'b0;
    logic [1:0] rst, valid, last, stall;
    logic [7:0] din [2];
    logic [1:0] ready, obit, oen, eop, busy, under;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    usb_tx_serializer #(.BIT_PERIOD(1), .EOP_BITS(EOP_BITS)) dut1 (
        .clk(clk), .RST(rst[0]), .data_in(din[0]), .data_valid(valid[0]),
        .data_last(last[0]), .data_ready(ready[0]), .stall(stall[0]),
        .out_bit(obit[0]), .out_en(oen[0]), .eop(eop[0]), .busy(busy[0]),
        .underrun(under[0])
    );

    usb_tx_serializer #(.BIT_PERIOD(4), .EOP_BITS(EOP_BITS)) dut4 (
        .clk(clk), .RST(rst[1]), .data_in(din[1]), .data_valid(valid[1]),
        .data_last(last[1]), .data_ready(ready[1]), .stall(stall[1]),
        .out_bit(obit[1]), .out_en(oen[1]), .eop(eop[1]), .busy(busy[1]),
        .underrun(under[1])
    );

    typedef struct {
        int          d;
        int          n;
        logic [31:0] bytes;
        bit          lastf;
        int          stall_at;
        bit          exp_under;
        int          exp_nbits;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mk(input int d, input int n, input logic [31:0] b,
                                input bit lf, input int st, input bit eu, input int enb);
        vec_t v;
        v.d = d; v.n = n; v.bytes = b; v.lastf = lf;
        v.stall_at = st; v.exp_under = eu; v.exp_nbits = enb;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 2'b11; valid = 2'b00; last = 2'b00; stall = 2'b00;
        din[0] = 8'h00; din[1] = 8'h00;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d.data_ready", d), int'(ready[d]), 1);
            chk($sformatf("reset%0d.out_bit", d), int'(obit[d]), 0);
            chk($sformatf("reset%0d.out_en", d), int'(oen[d]), 0);
            chk($sformatf("reset%0d.eop", d), int'(eop[d]), 0);
            chk($sformatf("reset%0d.busy", d), int'(busy[d]), 0);
            chk($sformatf("reset%0d.underrun", d), int'(under[d]), 0);
        end
        rst = 2'b00;
    endtask

    // Drive one packet and check its serial stream and framing against the rules
    task automatic run_pkt(input int d, input int n, input logic [31:0] bytes,
                           input bit lastf, input int stall_at, input bit rnd,
                           input bit exp_under, input int exp_nbits, input string tag);
        int bp;
        logic [63:0] exp_v, got_v;
        logic [7:0] syncb, cur;
        int pos, nb, idx, cyc, acc_cyc, first_en, prev_en, strobes;
        int sp_bad, stab_bad, eop_cnt, und_cnt, ov_bad, rdy_bad, rep_bad;
        bit acc_pend, started, done, prev_busy, prev_cons, prev_bit, prev_eop;
        bit last_acc, rep_pend, rep_bit;
        bp = (d == 0) ? 1 : 4;
        exp_v = '0; got_v = '0; pos = 0;
        syncb = 8'h80;
        for (int i = 0; i < SB; i++) begin exp_v[pos] = syncb[i]; pos++; end
        for (int k = 0; k < n; k++) begin
            cur = bytes[8*k +: 8];
            for (int i = 0; i < 8; i++) begin exp_v[pos] = cur[i]; pos++; end
        end
        nb = 0; idx = 0; cyc = 0; acc_cyc = -1; first_en = -1; prev_en = -1; strobes = 0;
        sp_bad = 0; stab_bad = 0; eop_cnt = 0; und_cnt = 0; ov_bad = 0; rdy_bad = 0; rep_bad = 0;
        acc_pend = 0; started = 0; done = 0; prev_busy = 0; prev_cons = 0; prev_bit = 0;
        prev_eop = 0; last_acc = 0; rep_pend = 0; rep_bit = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            if (acc_pend) begin idx++; acc_pend = 0; end
            valid[d] = (idx < n);
            din[d]   = (idx < n) ? bytes[8*idx +: 8] : 8'h00;
            last[d]  = lastf && (idx == n - 1);
            stall[d] = rnd ? ($urandom_range(0, 3) == 0) : (oen[d] && strobes == stall_at);
            if (last_acc && ready[d] && busy[d]) rdy_bad++;
            if (valid[d] && ready[d]) begin
                acc_pend = 1;
                if (acc_cyc < 0) acc_cyc = cyc;
                if (last[d]) last_acc = 1;
            end
            if (oen[d]) begin
                if (first_en < 0) first_en = cyc;
                if (prev_en >= 0 && cyc - prev_en != bp) sp_bad++;
                prev_en = cyc;
                if (rep_pend) begin
                    if (obit[d] != rep_bit) rep_bad++;
                    rep_pend = 0;
                end
                if (stall[d]) begin
                    rep_pend = 1; rep_bit = obit[d];
                end else begin
                    if (nb < 64) got_v[nb] = obit[d];
                    nb++;
                end
                strobes++;
            end
            if (busy[d] && prev_busy && !prev_cons && obit[d] != prev_bit) stab_bad++;
            if (eop[d]) eop_cnt++;
            if (eop[d] && oen[d]) ov_bad++;
            if (under[d]) und_cnt++;
            if (busy[d]) started = 1;
            else if (started) done = 1;
            prev_cons = oen[d] && !stall[d];
            prev_bit  = obit[d];
            prev_busy = busy[d];
            if (!done) prev_eop = eop[d];
            cyc++;
        end
        valid[d] = 1'b0; last[d] = 1'b0; stall[d] = 1'b0;
        chk({tag, ".finished"}, int'(done), 1);
        chk({tag, ".nbits"}, nb, exp_nbits);
        chk64({tag, ".stream"}, got_v, exp_v);
        chk({tag, ".latency"}, first_en - acc_cyc, bp);
        chk({tag, ".strobe_gap_bad"}, sp_bad, 0);
        chk({tag, ".bit_unstable"}, stab_bad, 0);
        chk({tag, ".stall_repeat_bad"}, rep_bad, 0);
        chk({tag, ".underrun_cycles"}, und_cnt, int'(exp_under));
        chk({tag, ".eop_cycles"}, eop_cnt, EOP_BITS * bp);
        chk({tag, ".out_en_in_eop"}, ov_bad, 0);
        chk({tag, ".ready_after_last"}, rdy_bad, 0);
        chk({tag, ".eop_before_idle"}, int'(prev_eop), 1);
        chk({tag, ".idle_eop"}, int'(eop[d]), 0);
        chk({tag, ".idle_ready"}, int'(ready[d]), 1);
    endtask

    initial begin
        int cnt, guard, d, n;
        logic [31:0] b;
        bit lf;

        tbl[0] = mk(0, 1, 32'h000000A5, 1, -1,     0, SB + 8);
        tbl[1] = mk(0, 2, 32'h0000FF01, 1, -1,     0, SB + 16);
        tbl[2] = mk(0, 1, 32'h000000FF, 1, SB + 2, 0, SB + 8);
        tbl[3] = mk(0, 1, 32'h0000003C, 0, -1,     1, SB + 8);
        tbl[4] = mk(1, 2, 32'h0000C35A, 1, SB + 5, 0, SB + 16);
        tbl[5] = mk(0, 1, 32'h00000080, 1, -1,     0, SB + 8);
        tbl[6] = mk(1, 1, 32'h00000080, 1, -1,     0, SB + 8);
        tbl[7] = mk(1, 3, 32'h00563412, 0, SB + 10, 1, SB + 24);

        do_reset();

        for (int i = 0; i < 8; i++) begin
            run_pkt(tbl[i].d, tbl[i].n, tbl[i].bytes, tbl[i].lastf, tbl[i].stall_at, 1'b0,
                    tbl[i].exp_under, tbl[i].exp_nbits, $sformatf("vec%0d", i));
        end

        // Reset asserted mid-DATA on the slow instance aborts with no EOP
        valid[1] = 1'b1; din[1] = 8'hC3; last[1] = 1'b1;
        @(posedge clk); #1;
        valid[1] = 1'b0; last[1] = 1'b0;
        cnt = 0; guard = 0;
        while (cnt < SB + 3 && guard < 500) begin
            if (oen[1]) cnt++;
            @(posedge clk); #1;
            guard++;
        end
        chk("rstmid.reached_data", int'(guard < 500), 1);
        chk("rstmid.pre_busy", int'(busy[1]), 1);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        chk("rstmid.busy", int'(busy[1]), 0);
        chk("rstmid.eop", int'(eop[1]), 0);
        chk("rstmid.out_en", int'(oen[1]), 0);
        chk("rstmid.out_bit", int'(obit[1]), 0);
        chk("rstmid.underrun", int'(under[1]), 0);
        chk("rstmid.data_ready", int'(ready[1]), 1);

        for (int i = 0; i < 24; i++) begin
            d  = int'($urandom_range(0, 1));
            n  = int'($urandom_range(1, 4));
            b  = $urandom;
            lf = ($urandom_range(0, 3) != 0);
            run_pkt(d, n, b, lf, -1, 1'b1, !lf, SB + 8 * n, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
